// File: rtl/VX_gpu_pkg.sv
// Shared GPU definitions: performance counter width and a constant-foldable clog2.
package VX_gpu_pkg;

  localparam int PERF_CTR_BITS = 44;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter: grants the first request strictly after the last grant,
// searching cyclically upward. Owns the last-grant register.
module vx_rr_arbiter import VX_gpu_pkg::*; #(
  parameter int NUM_REQS = 4,
  localparam int SELW = (NUM_REQS > 1) ? clog2(NUM_REQS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  input  logic                enable,
  output logic [NUM_REQS-1:0] grant,
  output logic [SELW-1:0]     grant_index,
  output logic                grant_valid
);

  assign grant_valid = |requests;

  if (NUM_REQS == 1) begin : g_single
    assign grant       = requests;
    assign grant_index = '0;
  end else begin : g_multi
    logic [SELW-1:0] last_grant_q, last_grant_d;
    logic            found;
    int              cand;

    always_comb begin
      grant       = '0;
      grant_index = '0;
      found       = 1'b0;
      cand        = 0;
      for (int i = 1; i <= NUM_REQS; i++) begin
        cand = int'(last_grant_q) + i;
        if (cand >= NUM_REQS) begin
          cand = cand - NUM_REQS;
        end
        if (!found && requests[cand[SELW-1:0]]) begin
          found                    = 1'b1;
          grant[cand[SELW-1:0]]    = 1'b1;
          grant_index              = cand[SELW-1:0];
        end
      end
    end

    // Idle cycles leave the pointer alone so fairness is preserved across gaps.
    always_comb begin
      last_grant_d = last_grant_q;
      if (enable && grant_valid) begin
        last_grant_d = grant_index;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        last_grant_q <= SELW'(NUM_REQS - 1);
      end else begin
        last_grant_q <= last_grant_d;
      end
    end
  end

endmodule

// File: rtl/vx_pipe_arbiter.sv
// Round-robin arbiter feeding one registered elastic output stage.
// Define VX_PIPE_ARB_PERF_EN to add stall/conflict performance counters.
module vx_pipe_arbiter import VX_gpu_pkg::*; #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 32,
  localparam int SELW    = (NUM_REQS > 1) ? clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       valid_in,
  output logic [NUM_REQS-1:0]       ready_in,
  input  logic [NUM_REQS*DATAW-1:0] data_in,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [DATAW-1:0]          data_out,
  output logic [SELW-1:0]           sel_out
`ifdef VX_PIPE_ARB_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0]  perf_stalls,
  output logic [PERF_CTR_BITS-1:0]  perf_conflicts
`endif
);

  logic                stall;
  logic [NUM_REQS-1:0] grant;
  logic [SELW-1:0]     grant_index;
  logic                grant_valid;
  logic [DATAW-1:0]    data_sel;

  logic                valid_q, valid_d;
  logic [DATAW-1:0]    data_q, data_d;
  logic [SELW-1:0]     sel_q, sel_d;

  assign stall    = valid_q && !ready_out;
  assign ready_in = grant & {NUM_REQS{!stall}};

  vx_rr_arbiter #(
    .NUM_REQS (NUM_REQS)
  ) u_rr_arbiter (
    .clk         (clk),
    .reset       (reset),
    .requests    (valid_in),
    .enable      (!stall),
    .grant       (grant),
    .grant_index (grant_index),
    .grant_valid (grant_valid)
  );

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant_index == SELW'(i)) begin
        data_sel = data_in[i*DATAW +: DATAW];
      end
    end
  end

  // The stage reloads whenever it is empty or draining, so a stall is the only hold case.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (!stall) begin
      valid_d = grant_valid;
      data_d  = data_sel;
      sel_d   = grant_index;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign sel_out   = sel_q;

`ifdef VX_PIPE_ARB_PERF_EN
  logic [PERF_CTR_BITS-1:0] stalls_q, stalls_d;
  logic [PERF_CTR_BITS-1:0] conflicts_q, conflicts_d;
  logic                     multi_valid;

  // Clearing the lowest set bit leaves a nonzero value iff two or more bits were set.
  assign multi_valid = |(valid_in & (valid_in - NUM_REQS'(1)));

  always_comb begin
    stalls_d    = stalls_q;
    conflicts_d = conflicts_q;
    if (stall) begin
      stalls_d = stalls_q + 1'b1;
    end
    if (!stall && multi_valid) begin
      conflicts_d = conflicts_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stalls_q    <= '0;
      conflicts_q <= '0;
    end else begin
      stalls_q    <= stalls_d;
      conflicts_q <= conflicts_d;
    end
  end

  assign perf_stalls    = stalls_q;
  assign perf_conflicts = conflicts_q;
`endif

endmodule

// File: tb/tb_vx_pipe_arbiter.sv
// Directed self-checking bench for vx_pipe_arbiter (NUM_REQS=4, DATAW=32).
// Perf counter checks are compiled in when VX_PIPE_ARB_PERF_EN is defined.
module tb_vx_pipe_arbiter;

  localparam int NUM_REQS = 4;
  localparam int DATAW    = 32;
  localparam int SELW     = 2;

  logic                      clk;
  logic                      reset;
  logic [NUM_REQS-1:0]       valid_in;
  logic [NUM_REQS-1:0]       ready_in;
  logic [NUM_REQS*DATAW-1:0] data_in;
  logic                      valid_out;
  logic                      ready_out;
  logic [DATAW-1:0]          data_out;
  logic [SELW-1:0]           sel_out;
`ifdef VX_PIPE_ARB_PERF_EN
  logic [43:0]               perf_stalls;
  logic [43:0]               perf_conflicts;
`endif

  int checkCount = 0;
  int passCount  = 0;

  vx_pipe_arbiter #(
    .NUM_REQS (NUM_REQS),
    .DATAW    (DATAW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .data_out  (data_out),
    .sel_out   (sel_out)
`ifdef VX_PIPE_ARB_PERF_EN
    ,
    .perf_stalls    (perf_stalls),
    .perf_conflicts (perf_conflicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NUM_REQS-1:0] v, input logic r);
    valid_in  = v;
    ready_out = r;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  initial begin
    reset     = 1'b1;
    valid_in  = '1;
    ready_out = 1'b1;
    for (int i = 0; i < NUM_REQS; i++) begin
      data_in[i*DATAW +: DATAW] = 32'h0000_00A0 + 32'(i);
    end

    tick();
    checkOutput("rst_valid", 64'(valid_out), 64'h0);
    checkOutput("rst_data", 64'(data_out), 64'h0);
    checkOutput("rst_sel", 64'(sel_out), 64'h0);
    checkOutput("rst_ready_in", 64'(ready_in), 64'h1);
    tick();
    checkOutput("rst_discard", 64'(valid_out), 64'h0);

    // Full contention: grants rotate 0,1,2,3,0.
    reset = 1'b0;
    applyStimulus(4'b1111, 1'b1);
    checkOutput("rr_ready_first", 64'(ready_in), 64'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("rr_valid", 64'(valid_out), 64'h1);
      checkOutput("rr_sel", 64'(sel_out), 64'(k % 4));
      checkOutput("rr_data", 64'(data_out), 64'(32'h0000_00A0 + 32'(k % 4)));
      checkOutput("rr_ready", 64'(ready_in), 64'(4'b0001 << ((k + 1) % 4)));
    end

    // Stall holds the captured transfer from requester 2.
    data_in[2*DATAW +: DATAW] = 32'hDEAD_BEEF;
    applyStimulus(4'b0100, 1'b1);
    checkOutput("st_ready_pre", 64'(ready_in), 64'h4);
    tick();
    applyStimulus(4'b0100, 1'b0);
    checkOutput("st_ready_stall", 64'(ready_in), 64'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("st_valid", 64'(valid_out), 64'h1);
      checkOutput("st_data", 64'(data_out), 64'hDEAD_BEEF);
      checkOutput("st_sel", 64'(sel_out), 64'h2);
      checkOutput("st_ready_in", 64'(ready_in), 64'h0);
    end
    applyStimulus(4'b0000, 1'b1);
    checkOutput("idle_ready", 64'(ready_in), 64'h0);
    tick();
    checkOutput("idle_valid_drop", 64'(valid_out), 64'h0);

    // Last grant 2 -> requester 3, then 0 and 3 contend: wrap to 0 first.
    applyStimulus(4'b1000, 1'b1);
    tick();
    checkOutput("wrap_sel3", 64'(sel_out), 64'h3);
    applyStimulus(4'b1001, 1'b1);
    checkOutput("wrap_ready0", 64'(ready_in), 64'h1);
    tick();
    checkOutput("wrap_sel0", 64'(sel_out), 64'h0);
    checkOutput("wrap_data0", 64'(data_out), 64'hA0);
    checkOutput("wrap_ready3", 64'(ready_in), 64'h8);
    tick();
    checkOutput("wrap_sel3b", 64'(sel_out), 64'h3);
    checkOutput("wrap_data3", 64'(data_out), 64'hA3);

    // Idle cycle keeps last grant at 0, so 1 beats 2.
    applyStimulus(4'b0001, 1'b1);
    tick();
    checkOutput("hold_sel0", 64'(sel_out), 64'h0);
    applyStimulus(4'b0000, 1'b1);
    tick();
    checkOutput("hold_idle", 64'(valid_out), 64'h0);
    applyStimulus(4'b0110, 1'b1);
    checkOutput("hold_ready1", 64'(ready_in), 64'h2);
    tick();
    checkOutput("hold_sel1", 64'(sel_out), 64'h1);
    checkOutput("hold_data1", 64'(data_out), 64'hA1);

    // Reset during a stalled transfer drops it and restores priority to 0.
    applyStimulus(4'b0000, 1'b0);
    tick();
    checkOutput("mr_held", 64'(valid_out), 64'h1);
    reset = 1'b1;
    tick();
    checkOutput("mr_valid", 64'(valid_out), 64'h0);
    reset = 1'b0;
    applyStimulus(4'b1111, 1'b1);
    checkOutput("mr_ready0", 64'(ready_in), 64'h1);
    tick();
    checkOutput("mr_sel0", 64'(sel_out), 64'h0);

`ifdef VX_PIPE_ARB_PERF_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(4'b0011, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
    end
    applyStimulus(4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
    end
    checkOutput("perf_stalls", 64'(perf_stalls), 64'd5);
    checkOutput("perf_conflicts", 64'(perf_conflicts), 64'd3);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
